// File: rtl/gpu_pkg.sv
// Shared scheduler types and helpers.
//   sched_state_t : block dispatcher FSM states
//   ceil_div_pow2 : ceiling division by a power of two, computed in 32 bits
package gpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_RESET_CORES = 2'd1,
    ST_DISPATCH    = 2'd2,
    ST_DRAIN       = 2'd3
  } sched_state_t;

  // 32-bit working width keeps n + divisor - 1 from overflowing for any TC_WIDTH < 32.
  function automatic logic [31:0] ceil_div_pow2(input logic [31:0] n, input int unsigned log2_d);
    logic [31:0] bias;
    bias = (32'd1 << log2_d) - 32'd1;
    return (n + bias) >> log2_d;
  endfunction

endpackage

// File: rtl/block_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req_i      : request vector, one bit per core
//   ptr_i      : highest-priority index for this cycle
//   gnt_o      : one-hot grant (all zero when nothing requests)
//   next_ptr_o : winner + 1 mod N, or ptr_i when there is no grant
module rr_arbiter #(
  parameter int unsigned N = 4,
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] next_ptr_o
);

  logic          found;
  logic [PW-1:0] idx;

  // Scan from ptr_i upward with wrap; first requester wins.
  always_comb begin
    gnt_o      = '0;
    next_ptr_o = ptr_i;
    found      = 1'b0;
    idx        = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = PW'((32'(ptr_i) + k) % N);
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        next_ptr_o = PW'((32'(idx) + 32'd1) % N);
      end
    end
  end

endmodule

// File: rtl/block_scheduler.sv
// Kernel block dispatcher: splits thread_count into blocks of THREADS_PER_BLOCK
// threads, hands one block per cycle to a free core (round-robin), counts
// completions and reports kernel done / abort.
//   clk, reset        : clock, synchronous active-high reset
//   start, abort      : launch on rising start while idle; abort a running kernel
//   thread_count      : total threads, latched at launch
//   core_done         : per-core block completion (level)
//   core_start        : per-core "executing a block"
//   core_reset        : per-core one-cycle reset pulse
//   core_block_id     : block id assigned to each core
//   core_thread_count : threads in each core's block
//   busy, done        : kernel running / kernel complete (held)
//   aborted           : one-cycle pulse on accepted abort
//   blocks_done       : completed-block counter
module block_scheduler
  import gpu_pkg::*;
#(
  parameter int unsigned NUM_CORES         = 4,
  parameter int unsigned THREADS_PER_BLOCK = 4,
  parameter int unsigned TC_WIDTH          = 16,
  localparam int unsigned BID_WIDTH = TC_WIDTH - $clog2(THREADS_PER_BLOCK) + 1,
  localparam int unsigned CTC_WIDTH = $clog2(THREADS_PER_BLOCK) + 1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic                                  abort,
  input  logic [TC_WIDTH-1:0]                   thread_count,
  input  logic [NUM_CORES-1:0]                  core_done,
  output logic [NUM_CORES-1:0]                  core_start,
  output logic [NUM_CORES-1:0]                  core_reset,
  output logic [NUM_CORES-1:0][BID_WIDTH-1:0]   core_block_id,
  output logic [NUM_CORES-1:0][CTC_WIDTH-1:0]   core_thread_count,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  aborted,
  output logic [BID_WIDTH-1:0]                  blocks_done
);

  localparam int unsigned LOG2_TPB = $clog2(THREADS_PER_BLOCK);
  localparam int unsigned PTR_W    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [CTC_WIDTH-1:0] FULL_CNT = CTC_WIDTH'(THREADS_PER_BLOCK);

  sched_state_t                           state_q, state_d;
  logic                                   start_q;
  logic [NUM_CORES-1:0]                   core_start_q, core_start_d;
  logic [NUM_CORES-1:0]                   core_reset_q, core_reset_d;
  logic [NUM_CORES-1:0][BID_WIDTH-1:0]    core_block_id_q, core_block_id_d;
  logic [NUM_CORES-1:0][CTC_WIDTH-1:0]    core_thread_count_q, core_thread_count_d;
  logic                                   busy_q, busy_d;
  logic                                   done_q, done_d;
  logic                                   aborted_q, aborted_d;
  logic [BID_WIDTH-1:0]                   blocks_done_q, blocks_done_d;
  logic [BID_WIDTH-1:0]                   total_q, total_d;
  logic [CTC_WIDTH-1:0]                   last_cnt_q, last_cnt_d;
  logic [BID_WIDTH-1:0]                   next_blk_q, next_blk_d;
  logic [PTR_W-1:0]                       rr_ptr_q, rr_ptr_d;

  logic [NUM_CORES-1:0] completing;
  logic [NUM_CORES-1:0] free_cores;
  logic [NUM_CORES-1:0] gnt;
  logic [PTR_W-1:0]     next_ptr;
  logic [31:0]          total_w;
  logic [31:0]          last_w;

  function automatic logic [BID_WIDTH-1:0] popcount(input logic [NUM_CORES-1:0] v);
    logic [BID_WIDTH-1:0] c;
    c = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) c = c + BID_WIDTH'(v[i]);
    return c;
  endfunction

  // Block count and last-block size from the live thread_count (used only at launch).
  assign total_w = ceil_div_pow2(32'(thread_count), LOG2_TPB);
  assign last_w  = 32'(thread_count) - ((total_w - 32'd1) << LOG2_TPB);

  // A core in its reset pulse is not yet free, so it is never reused on its completion edge.
  assign free_cores = ~core_start_q & ~core_reset_q;

  rr_arbiter #(.N(NUM_CORES)) u_arb (
    .req_i      (free_cores),
    .ptr_i      (rr_ptr_q),
    .gnt_o      (gnt),
    .next_ptr_o (next_ptr)
  );

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q             <= ST_IDLE;
      start_q             <= 1'b0;
      core_start_q        <= '0;
      core_reset_q        <= '1;
      core_block_id_q     <= '0;
      core_thread_count_q <= {NUM_CORES{FULL_CNT}};
      busy_q              <= 1'b0;
      done_q              <= 1'b0;
      aborted_q           <= 1'b0;
      blocks_done_q       <= '0;
      total_q             <= '0;
      last_cnt_q          <= FULL_CNT;
      next_blk_q          <= '0;
      rr_ptr_q            <= '0;
    end else begin
      state_q             <= state_d;
      start_q             <= start;
      core_start_q        <= core_start_d;
      core_reset_q        <= core_reset_d;
      core_block_id_q     <= core_block_id_d;
      core_thread_count_q <= core_thread_count_d;
      busy_q              <= busy_d;
      done_q              <= done_d;
      aborted_q           <= aborted_d;
      blocks_done_q       <= blocks_done_d;
      total_q             <= total_d;
      last_cnt_q          <= last_cnt_d;
      next_blk_q          <= next_blk_d;
      rr_ptr_q            <= rr_ptr_d;
    end
  end

  // Next-state: launch, dispatch, completion counting, drain, abort.
  always_comb begin
    state_d             = state_q;
    core_start_d        = core_start_q;
    core_reset_d        = '0;
    core_block_id_d     = core_block_id_q;
    core_thread_count_d = core_thread_count_q;
    busy_d              = busy_q;
    done_d              = done_q;
    aborted_d           = 1'b0;
    blocks_done_d       = blocks_done_q;
    total_d             = total_q;
    last_cnt_d          = last_cnt_q;
    next_blk_d          = next_blk_q;
    rr_ptr_d            = rr_ptr_q;
    completing          = core_start_q & core_done;

    case (state_q)
      ST_IDLE: begin
        if (start && !start_q) begin
          done_d        = 1'b0;
          blocks_done_d = '0;
          total_d       = BID_WIDTH'(total_w);
          last_cnt_d    = CTC_WIDTH'(last_w);
          next_blk_d    = '0;
          rr_ptr_d      = '0;
          if (thread_count == '0) begin
            done_d = 1'b1;
          end else begin
            busy_d       = 1'b1;
            core_reset_d = '1;
            state_d      = ST_RESET_CORES;
          end
        end
      end
      ST_RESET_CORES: state_d = ST_DISPATCH;
      ST_DISPATCH, ST_DRAIN: begin
        core_start_d  = core_start_q & ~completing;
        core_reset_d  = completing;
        blocks_done_d = blocks_done_q + popcount(completing);
        if (state_q == ST_DISPATCH) begin
          if (|gnt) begin
            for (int unsigned i = 0; i < NUM_CORES; i++) begin
              if (gnt[i]) begin
                core_start_d[i]        = 1'b1;
                core_block_id_d[i]     = next_blk_q;
                core_thread_count_d[i] = (next_blk_q == total_q - BID_WIDTH'(1)) ? last_cnt_q : FULL_CNT;
              end
            end
            next_blk_d = next_blk_q + BID_WIDTH'(1);
            rr_ptr_d   = next_ptr;
            if (next_blk_d == total_q) state_d = ST_DRAIN;
          end
        end else if (blocks_done_d == total_q) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort wins over any completion or dispatch on the same edge.
    if (abort && state_q != ST_IDLE) begin
      core_start_d        = '0;
      core_reset_d        = '1;
      core_block_id_d     = core_block_id_q;
      core_thread_count_d = core_thread_count_q;
      busy_d              = 1'b0;
      done_d              = done_q;
      aborted_d           = 1'b1;
      blocks_done_d       = blocks_done_q;
      next_blk_d          = next_blk_q;
      rr_ptr_d            = rr_ptr_q;
      state_d             = ST_IDLE;
    end
  end

  assign core_start        = core_start_q;
  assign core_reset        = core_reset_q;
  assign core_block_id     = core_block_id_q;
  assign core_thread_count = core_thread_count_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign aborted           = aborted_q;
  assign blocks_done       = blocks_done_q;

endmodule
